// File: rtl/demux_1to8_reg.sv
// Registered 1-to-8 lane demultiplexer with auto pointer and frame tracking.
// Rebuilds a parallel word from a serial lane stream.
module demux_1to8_reg #(
  parameter int DATA_W = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [DATA_W-1:0]   y_in,
  input  logic                valid_in,
  input  logic [2:0]          sel_in,
  input  logic                auto_in,
  input  logic                clr_in,
  output logic [8*DATA_W-1:0] d_out,
  output logic [7:0]          strobe_out,
  output logic [2:0]          sel_out,
  output logic                frame_done_out,
  output logic                busy_out
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state, state_nx;
  logic [7:0]          mask, mask_nx;
  logic [7:0]          onehot, mask_or;
  logic [2:0]          ptr, ptr_nx, dest;
  logic [8*DATA_W-1:0] lanes, lanes_nx;
  logic [7:0]          strobe_nx;
  logic                done_nx;

  always_comb begin
    dest      = auto_in ? ptr : sel_in;
    onehot    = 8'b1 << dest;
    mask_or   = mask | onehot;
    state_nx  = state;
    mask_nx   = mask;
    ptr_nx    = ptr;
    lanes_nx  = lanes;
    strobe_nx = '0;
    done_nx   = 1'b0;
    // clear wins over a simultaneous write
    if (clr_in) begin
      state_nx = IDLE;
      mask_nx  = '0;
      ptr_nx   = '0;
    end else if (valid_in) begin
      lanes_nx[dest*DATA_W +: DATA_W] = y_in;
      strobe_nx = onehot;
      if (auto_in)
        ptr_nx = ptr + 3'd1;
      if (mask_or == 8'hFF) begin
        mask_nx  = '0;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end else begin
        mask_nx  = mask_or;
        state_nx = FILL;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      mask           <= '0;
      ptr            <= '0;
      lanes          <= '0;
      strobe_out     <= '0;
      frame_done_out <= 1'b0;
    end else begin
      state          <= state_nx;
      mask           <= mask_nx;
      ptr            <= ptr_nx;
      lanes          <= lanes_nx;
      strobe_out     <= strobe_nx;
      frame_done_out <= done_nx;
    end
  end

  assign d_out    = lanes;
  assign sel_out  = ptr;
  assign busy_out = (state == FILL);

endmodule

// File: tb/tb_demux_1to8_reg.sv
// Scoreboard bench for demux_1to8_reg: driver queues hand-computed
// responses, a negedge monitor pops and compares them.
module tb_demux_1to8_reg;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [0:0] y_in = '0;
  logic       valid_in = 1'b0;
  logic [2:0] sel_in = '0;
  logic       auto_in = 1'b0;
  logic       clr_in = 1'b0;
  logic [7:0] d_out;
  logic [7:0] strobe_out;
  logic [2:0] sel_out;
  logic       frame_done_out;
  logic       busy_out;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [7:0] strobe;
    logic [7:0] d;
    logic       done;
    logic [2:0] sel;
    logic       busy;
  } exp_t;

  exp_t q[$];

  demux_1to8_reg #(.DATA_W(1)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .y_in(y_in),
    .valid_in(valid_in),
    .sel_in(sel_in),
    .auto_in(auto_in),
    .clr_in(clr_in),
    .d_out(d_out),
    .strobe_out(strobe_out),
    .sel_out(sel_out),
    .frame_done_out(frame_done_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic void chk(input string nm,
                              input logic [7:0] act,
                              input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("strobe", strobe_out, e.strobe);
      chk("d_out", d_out, e.d);
      chk("frame_done", {7'd0, frame_done_out}, {7'd0, e.done});
      chk("sel_out", {5'd0, sel_out}, {5'd0, e.sel});
      chk("busy", {7'd0, busy_out}, {7'd0, e.busy});
    end
  end

  task automatic step(input logic v, input logic a,
                      input logic [2:0] s, input logic y,
                      input logic c,
                      input logic [7:0] es, input logic [7:0] ed,
                      input logic edn, input logic [2:0] esel,
                      input logic ebusy);
    exp_t e;
    valid_in = v;
    auto_in  = a;
    sel_in   = s;
    y_in     = y;
    clr_in   = c;
    e.strobe = es;
    e.d      = ed;
    e.done   = edn;
    e.sel    = esel;
    e.busy   = ebusy;
    @(posedge clk_in);
    q.push_back(e);
    #1;
  endtask

  task automatic idle_in();
    valid_in = 1'b0;
    clr_in   = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_in);
    chk("rst_d", d_out, 8'h00);
    chk("rst_strobe", strobe_out, 8'h00);
    chk("rst_misc", {sel_out, frame_done_out, busy_out}, 8'h00);
    rst_in = 1'b0;

    // auto fill, then back-to-back manual frame
    step(1,1,0,1,0, 8'h01,8'h01,0,1,1);
    step(1,1,0,0,0, 8'h02,8'h01,0,2,1);
    step(1,1,0,1,0, 8'h04,8'h05,0,3,1);
    step(1,1,0,1,0, 8'h08,8'h0D,0,4,1);
    step(1,1,0,0,0, 8'h10,8'h0D,0,5,1);
    step(1,1,0,0,0, 8'h20,8'h0D,0,6,1);
    step(1,1,0,1,0, 8'h40,8'h4D,0,7,1);
    step(1,1,0,0,0, 8'h80,8'h4D,1,0,0);

    // manual scatter
    step(1,0,7,1,0, 8'h80,8'hCD,0,0,1);
    step(1,0,3,1,0, 8'h08,8'hCD,0,0,1);
    step(1,0,0,1,0, 8'h01,8'hCD,0,0,1);
    step(1,0,5,1,0, 8'h20,8'hED,0,0,1);
    step(1,0,1,1,0, 8'h02,8'hEF,0,0,1);
    step(1,0,6,1,0, 8'h40,8'hEF,0,0,1);
    step(1,0,2,1,0, 8'h04,8'hEF,0,0,1);
    step(1,0,4,1,0, 8'h10,8'hFF,1,0,0);
    step(0,0,0,0,0, 8'h00,8'hFF,0,0,0);

    // rewrite lane 1
    step(1,0,0,1,0, 8'h01,8'hFF,0,0,1);
    step(1,0,1,1,0, 8'h02,8'hFF,0,0,1);
    step(1,0,2,1,0, 8'h04,8'hFF,0,0,1);
    step(1,0,1,0,0, 8'h02,8'hFD,0,0,1);
    step(1,0,3,1,0, 8'h08,8'hFD,0,0,1);
    step(1,0,4,1,0, 8'h10,8'hFD,0,0,1);
    step(1,0,5,1,0, 8'h20,8'hFD,0,0,1);
    step(1,0,6,1,0, 8'h40,8'hFD,0,0,1);
    step(1,0,7,1,0, 8'h80,8'hFD,1,0,0);
    step(0,0,0,0,0, 8'h00,8'hFD,0,0,0);

    // clear beats a simultaneous write
    step(1,1,0,0,0, 8'h01,8'hFC,0,1,1);
    step(1,1,0,1,0, 8'h02,8'hFE,0,2,1);
    step(1,1,0,0,0, 8'h04,8'hFA,0,3,1);
    step(1,1,0,1,0, 8'h08,8'hFA,0,4,1);
    step(1,1,0,1,1, 8'h00,8'hFA,0,0,0);
    step(1,1,0,0,0, 8'h01,8'hFA,0,1,1);
    step(1,1,0,1,0, 8'h02,8'hFA,0,2,1);
    step(1,1,0,1,0, 8'h04,8'hFE,0,3,1);
    step(1,1,0,0,0, 8'h08,8'hF6,0,4,1);
    step(1,1,0,0,0, 8'h10,8'hE6,0,5,1);
    step(1,1,0,0,0, 8'h20,8'hC6,0,6,1);
    step(1,1,0,1,0, 8'h40,8'hC6,0,7,1);
    step(1,1,0,1,0, 8'h80,8'hC6,1,0,0);
    step(0,0,0,0,0, 8'h00,8'hC6,0,0,0);

    // async reset mid-frame
    step(1,1,0,1,0, 8'h01,8'hC7,0,1,1);
    step(1,1,0,1,0, 8'h02,8'hC7,0,2,1);
    step(1,1,0,1,0, 8'h04,8'hC7,0,3,1);
    step(1,1,0,1,0, 8'h08,8'hCF,0,4,1);
    step(1,1,0,1,0, 8'h10,8'hDF,0,5,1);
    idle_in();
    @(negedge clk_in);
    #1 rst_in = 1'b1;
    #1;
    chk("arst_d", d_out, 8'h00);
    chk("arst_strobe", strobe_out, 8'h00);
    chk("arst_misc", {sel_out, frame_done_out, busy_out}, 8'h00);
    #1 rst_in = 1'b0;
    step(0,0,0,0,0, 8'h00,8'h00,0,0,0);

    // mixed auto/manual completion
    step(1,1,0,1,0, 8'h01,8'h01,0,1,1);
    step(1,1,0,1,0, 8'h02,8'h03,0,2,1);
    step(1,1,0,1,0, 8'h04,8'h07,0,3,1);
    step(1,0,3,1,0, 8'h08,8'h0F,0,3,1);
    step(1,0,4,1,0, 8'h10,8'h1F,0,3,1);
    step(1,0,5,1,0, 8'h20,8'h3F,0,3,1);
    step(1,0,6,1,0, 8'h40,8'h7F,0,3,1);
    step(1,1,5,0,0, 8'h08,8'h77,0,4,1);
    step(1,0,7,1,0, 8'h80,8'hF7,1,4,0);
    step(0,0,0,0,0, 8'h00,8'hF7,0,4,0);
    idle_in();

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk_in);
    @(posedge clk_in);
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/demux_1to8_reg.md
Name: demux_1to8_reg

Overview:
- Registered 1-to-8 demultiplexer. It is the inverse of the team's 8:1 mux: one input lane is steered into one of eight held output lanes.
- The destination lane is chosen either by an explicit select or by an internal auto-incrementing pointer.
- A valid-qualified write updates only the addressed lane. A completion pulse fires once all eight lanes have been written since the last frame start.
- Used to rebuild a parallel word from a lane stream produced by the mux-side logic.

Parameters:
- DATA_W, 1, width of the input lane and of each output lane.

Ports:
- clk_in, input, 1, single clock, rising edge.
- rst_in, input, 1, reset: asynchronous, active-high.
- y_in, input, DATA_W, lane data to be distributed.
- valid_in, input, 1, write strobe; y_in is sampled when this is high.
- sel_in, input, 3, explicit destination lane, used when auto_in=0.
- auto_in, input, 1, 1 = destination is the internal pointer; 0 = destination is sel_in.
- clr_in, input, 1, synchronous frame clear.
- d_out, output, 8*DATA_W, held lanes; lane k occupies bits [k*DATA_W +: DATA_W].
- strobe_out, output, 8, one-hot registered pulse marking the lane written in the previous cycle.
- sel_out, output, 3, current internal pointer value.
- frame_done_out, output, 1, one-cycle pulse when the written-lane mask becomes complete.
- busy_out, output, 1, high while state is FILL.

Behaviour:
- Reset (async assert; release is synchronous to clk_in): d_out=0, strobe_out=0, sel_out=0, frame_done_out=0, busy_out=0, mask=0, state=IDLE.
- Destination lane: dest = auto_in ? pointer : sel_in, evaluated in the cycle valid_in is high.
- Write: on a clock edge with valid_in=1 and clr_in=0, the following happen in the same edge, i.e. outputs are visible on the next cycle (latency 1):
  - lane[dest] <= y_in.
  - strobe_out <= one-hot(dest); strobe_out is 0 on cycles with no write.
  - mask[dest] <= 1.
  - All other lanes hold.
- Pointer:
  - Advances by 1 only on auto-mode writes.
  - Wraps 7->0 with no flag.
  - Manual writes do not move it. sel_out reflects it directly.
- State machine, states IDLE and FILL:
  - IDLE (mask=0) -> FILL on any accepted write, unless that write completes the mask.
  - FILL -> IDLE when the mask becomes 8'hFF. At that edge frame_done_out <= 1 for exactly one cycle and mask <= 0; the completing lane's data is still stored.
  - FILL -> IDLE on clr_in.
  - busy_out = (state==FILL).
- Rewrite of an already-marked lane: data is updated and strobe_out pulses; the mask is unchanged and frame_done_out does not fire.
- clr_in=1: mask <= 0, pointer <= 0, state <= IDLE, strobe_out <= 0, frame_done_out <= 0. d_out is held, not cleared. clr_in takes priority over a simultaneous valid_in; that write is dropped.
- Switching auto_in mid-frame is legal. The mask carries across modes; completion can mix auto and manual writes.
- Back-to-back frames: a write in the cycle after the frame_done edge starts a new frame with no gap cycle.
- rst_in asserted mid-frame: all state and outputs return to reset values immediately, without waiting for a clock edge.
- No X propagation: sel_in is ignored when valid_in=0 or auto_in=1.

Test Plan:
- Auto fill (DATA_W=1): assert rst_in, release; auto_in=1, valid_in=1 for 8 cycles with y_in = 1,0,1,1,0,0,1,0.
  - Required: d_out=8'b0100_1101.
  - strobe_out walks 01,02,...,80.
  - frame_done_out high exactly one cycle after the 8th write; sel_out back to 0; busy_out low.
- Manual scatter: auto_in=0, write sel_in = 7,3,0,5,1,6,2,4 with y_in=1 each.
  - Required: frame_done_out only after sel 4; d_out=8'hFF; sel_out stays 0 throughout.
- Rewrite: manual writes to lanes 0,1,2, then lane 1 again with y_in=0, then lanes 3..7.
  - Required: lane1=0; frame_done_out fires only after lane 7; exactly one pulse.
- Clear priority: auto mode, 4 writes, then clr_in=1 together with valid_in=1, y_in=1.
  - Required: write dropped; d_out lanes 0-3 held; sel_out=0; busy_out=0; no frame_done_out.
  - 8 further auto writes give frame_done_out once.
- Async reset mid-frame: after 5 auto writes, pulse rst_in between clock edges.
  - Required: d_out=0, sel_out=0, busy_out=0 before the next edge.
- Mixed mode and wrap: 3 auto writes (lanes 0-2), then manual lanes 3-6, then auto_in=1 for one write (pointer=3), then manual lane 7.
  - Required: completion on the lane-7 write; the auto write to lane 3 does not set frame_done_out; sel_out=4 afterwards.
